// File: rtl/ak6551_rx.sv
// rtl/ak6551_rx.sv - 6551 ACIA serial receive engine: 16x oversampled deframer with error flags
module ak6551_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       baud16,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic [1:0] word_len,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   tick;
    logic [3:0]             cnt_q;
    logic [2:0]             bit_q;
    logic [2:0]             last_bit;
    logic [7:0]             shift_q;
    logic                   par_acc_q;
    logic                   par_bad_q;
    logic                   par_fail;
    logic                   load;

    logic cnt_clr;
    logic start_data;
    logic shift_en;
    logic par_chk;
    logic stop_samp;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign tick     = clk_en & baud16;
    assign last_bit = 3'd7 - {1'b0, word_len};
    assign rx_busy  = (state_q != S_IDLE);
    assign load     = stop_samp & (~rx_full | rx_read);

    always_comb begin
        case (parity_mode)
            2'b00:   par_fail = ~(par_acc_q ^ rxs);
            2'b01:   par_fail = par_acc_q ^ rxs;
            2'b10:   par_fail = ~rxs;
            default: par_fail = rxs;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else if (clk_en) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        start_data = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        stop_samp  = 1'b0;
        if (clk_en) begin
            if (!rx_en) begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end else if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rxs) begin
                            state_d = S_START;
                            cnt_clr = 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt_q == 4'd7) begin
                            if (!rxs) begin
                                state_d    = S_DATA;
                                cnt_clr    = 1'b1;
                                start_data = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == 4'd15) begin
                            shift_en = 1'b1;
                            // >= keeps a live word_len change from stranding the FSM
                            if (bit_q >= last_bit) begin
                                state_d = parity_en ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (cnt_q == 4'd15) begin
                            par_chk = 1'b1;
                            state_d = S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (cnt_q == 4'd15) begin
                            stop_samp = 1'b1;
                            state_d   = rxs ? S_IDLE : S_BREAK;
                        end
                    end
                    S_BREAK: begin
                        if (rxs) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_acc_q <= 1'b0;
            par_bad_q <= 1'b0;
        end else if (clk_en) begin
            if (cnt_clr) begin
                cnt_q <= 4'd0;
            end else if (tick) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (start_data) begin
                bit_q     <= 3'd0;
                par_acc_q <= 1'b0;
                par_bad_q <= 1'b0;
            end
            if (shift_en) begin
                shift_q   <= {rxs, shift_q[7:1]};
                bit_q     <= bit_q + 3'd1;
                par_acc_q <= par_acc_q ^ rxs;
            end
            if (par_chk) begin
                par_bad_q <= par_fail;
            end
        end
    end

    // Data enters at the MSB, so short words are right-aligned by word_len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= 8'h00;
            rx_full     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (clk_en) begin
            if (load) begin
                rx_data     <= shift_q >> word_len;
                rx_full     <= 1'b1;
                parity_err  <= parity_en & par_bad_q;
                framing_err <= ~rxs;
                overrun     <= 1'b0;
            end else begin
                if (rx_read) begin
                    rx_full     <= 1'b0;
                    parity_err  <= 1'b0;
                    framing_err <= 1'b0;
                    overrun     <= 1'b0;
                end
                if (stop_samp) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ak6551_rx.sv
// tb/tb_ak6551_rx.sv - scoreboard bench for ak6551_rx with randomized frames
module tb_ak6551_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1;
    logic       baud16 = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_en = 1'b1;
    logic [1:0] word_len = 2'b00;
    logic       parity_en = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       parity_err;
    logic       framing_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         tick;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   model_full = 1'b0;
    logic read_at_edge = 1'b0;
    logic full_prev = 1'b0;

    ak6551_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .baud16(baud16), .rxd(rxd),
        .rx_en(rx_en), .word_len(word_len), .parity_en(parity_en),
        .parity_mode(parity_mode), .rx_read(rx_read), .rx_data(rx_data),
        .rx_full(rx_full), .parity_err(parity_err), .framing_err(framing_err),
        .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Tick count is taken at the edge; baud16 moves 2ns later so nothing races it.
    initial forever begin
        @(posedge clk);
        if (baud16 && clk_en && rst_n) tick_cnt++;
        #2;
        cyc++;
        baud16 = (cyc % 4 == 0);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) read_at_edge <= rx_read & clk_en;

    always @(negedge clk) begin
        if (rst_n && rx_full && (!full_prev || read_at_edge)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got data %0h, required no load", rx_data);
            end else begin
                mon_e = sb.pop_front();
                chk("load_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                chk("load_perr", {31'd0, parity_err}, {31'd0, mon_e.perr});
                chk("load_ferr", {31'd0, framing_err}, {31'd0, mon_e.ferr});
                chk("load_ovr", {31'd0, overrun}, 32'd0);
                chk("load_tick", tick_cnt, mon_e.tick);
            end
        end
        full_prev = rx_full;
    end

    function automatic int nbits(input logic [1:0] wl);
        return 8 - int'(wl);
    endfunction

    function automatic logic ref_perr(input logic [7:0] d, input int n, input bit pe,
                                      input logic [1:0] m, input bit pb);
        int ones = 0;
        if (!pe) return 1'b0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        case (m)
            2'b00:   return ((ones + int'(pb)) % 2) != 1;
            2'b01:   return ((ones + int'(pb)) % 2) != 0;
            2'b10:   return pb != 1'b1;
            default: return pb != 1'b0;
        endcase
    endfunction

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic align_tick();
        @(negedge clk);
        while (!baud16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pb, input bit stopb,
                              input int extra_low, input bit collide);
        int n;
        int exp_tick;
        exp_t e;
        n = nbits(word_len);
        align_tick();
        exp_tick = tick_cnt + 2 + 8 + 16 * (n + int'(parity_en) + 1);
        e.data = d & (8'hFF >> (8 - n));
        e.perr = ref_perr(d, n, parity_en, parity_mode, pb);
        e.ferr = ~stopb;
        e.tick = exp_tick;
        if (!model_full || collide) begin
            sb.push_back(e);
            model_full = 1'b1;
        end
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (parity_en) drive_bit(pb);
        rxd = stopb;
        repeat (64) begin
            if (collide) rx_read = (baud16 && (tick_cnt + 1 == exp_tick));
            @(negedge clk);
        end
        rx_read = 1'b0;
        if (extra_low > 0) begin
            rxd = 1'b0;
            repeat (extra_low * 4) @(negedge clk);
        end
        rxd = 1'b1;
        idle(32);
    endtask

    task automatic do_read();
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        model_full = 1'b0;
    endtask

    task automatic chk_clear(input string name);
        chk({name, "_full"}, {31'd0, rx_full}, 32'd0);
        chk({name, "_perr"}, {31'd0, parity_err}, 32'd0);
        chk({name, "_ferr"}, {31'd0, framing_err}, 32'd0);
        chk({name, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk_clear("rst");
        rst_n = 1'b1;
        idle(10);

        // 8N1
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("t1_full", {31'd0, rx_full}, 32'd1);
        do_read();
        chk_clear("t1_read");

        // 7E1 good then bad parity
        word_len = 2'b01; parity_en = 1'b1; parity_mode = 2'b01;
        send_frame(8'h41, 1'b0, 1'b1, 0, 1'b0);
        do_read();
        send_frame(8'h41, 1'b1, 1'b1, 0, 1'b0);
        chk("t2_perr", {31'd0, parity_err}, 32'd1);
        do_read();

        // framing error followed by a held-low break
        word_len = 2'b00; parity_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 40, 1'b0);
        chk("t3_ferr", {31'd0, framing_err}, 32'd1);
        chk("t3_busy", {31'd0, rx_busy}, 32'd0);
        do_read();
        send_frame(8'h33, 1'b0, 1'b1, 0, 1'b0);
        do_read();

        // overrun, clk_en gating of rx_read, then clear
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("t4_ovr", {31'd0, overrun}, 32'd1);
        chk("t4_data", {24'd0, rx_data}, 32'h11);
        chk("t4_full", {31'd0, rx_full}, 32'd1);
        @(negedge clk);
        clk_en = 1'b0;
        rx_read = 1'b1;
        idle(3);
        rx_read = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        chk("t4_gated_full", {31'd0, rx_full}, 32'd1);
        chk("t4_gated_ovr", {31'd0, overrun}, 32'd1);
        do_read();
        chk_clear("t4_read");

        // read collides with the stop-sample load
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1, 0, 1'b1);
        chk("t5_data", {24'd0, rx_data}, 32'h7E);
        chk("t5_full", {31'd0, rx_full}, 32'd1);
        chk("t5_ovr", {31'd0, overrun}, 32'd0);
        do_read();

        // randomized formats
        for (int k = 0; k < 10; k++) begin
            word_len    = 2'($urandom_range(0, 3));
            parity_en   = 1'($urandom_range(0, 1));
            parity_mode = 2'($urandom_range(0, 3));
            send_frame(8'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) != 0), 0, 1'b0);
            do_read();
        end
        word_len = 2'b00; parity_en = 1'b0;

        // 4-tick glitch is rejected
        align_tick();
        rxd = 1'b0;
        idle(16);
        chk("t6_glitch_busy", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        idle(60);
        chk("t6_glitch_idle", {31'd0, rx_busy}, 32'd0);
        chk_clear("t6_glitch");

        // rx_en abort mid-frame
        align_tick();
        rxd = 1'b0;
        idle(192);
        chk("t6_abort_busy", {31'd0, rx_busy}, 32'd1);
        rx_en = 1'b0;
        idle(2);
        chk("t6_abort_idle", {31'd0, rx_busy}, 32'd0);
        rxd = 1'b1;
        idle(8);
        rx_en = 1'b1;
        idle(700);
        chk("t6_abort_noload", {31'd0, rx_full}, 32'd0);

        // reset mid-frame with flags held
        send_frame(8'h55, 1'b0, 1'b0, 0, 1'b0);
        align_tick();
        rxd = 1'b0;
        idle(100);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", {24'd0, rx_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk_clear("t6_rst");
        model_full = 1'b0;
        idle(3);
        rxd = 1'b1;
        rst_n = 1'b1;
        idle(100);
        send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
        do_read();

        idle(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending loads, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ak6551_rx.md
# ak6551_rx

Serial receive engine for the 6551-compatible ACIA. It samples the `rxd` line using a 16x oversampling tick from the baud-rate generator and deframes start, data, parity and stop bits. It then hands the assembled byte and its error flags to the ACIA register file, which exposes them as the receive-data and status registers. The block sits directly upstream of the register file and is cleared by the register file's receive-data read strobe.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of `rxd` synchronizer flops; minimum 2.

Ports:
- `clk` in 1: system clock; all logic is single-clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clk_en` in 1: global clock enable; no state changes when low.
- `baud16` in 1: 16x baud tick, one `clk` wide; honoured only when `clk_en`=1.
- `rxd` in 1: asynchronous serial input; idle level is 1.
- `rx_en` in 1: receiver enable; 0 aborts and holds the FSM in IDLE.
- `word_len` in 2: data bits; 00=8, 01=7, 10=6, 11=5.
- `parity_en` in 1: 1 means a parity bit follows the data bits.
- `parity_mode` in 2: 00=odd, 01=even, 10=mark (bit must be 1), 11=space (bit must be 0).
- `rx_read` in 1: one-cycle strobe from the register file when the CPU reads receive data.
- `rx_data` out 8: last received word, LSB-aligned, unused upper bits 0.
- `rx_full` out 1: receive data register full.
- `parity_err` out 1: parity error for the word in `rx_data`.
- `framing_err` out 1: stop bit was sampled as 0 for the word in `rx_data`.
- `overrun` out 1: a frame completed while `rx_full` was 1; that frame was lost.
- `rx_busy` out 1: FSM is not in IDLE.

## Operation
- Synchronizer: `SYNC_STAGES` flops on `rxd`, reset to 1. All decisions below use the synchronized value `rxs`.
- Sample counter `cnt[3:0]` advances on each qualified `baud16` tick (`clk_en & baud16`).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a qualified tick with `rxs`=0, go to START with `cnt`=0.
- START: when `cnt`=7 (the mid-bit sample), re-check `rxs`.
  - `rxs`=0: go to DATA with `cnt`=0 and bit index 0.
  - `rxs`=1: treat as a false start and return to IDLE with no flag change.
- DATA: sample when `cnt`=15, which is 16 ticks after the previous mid-bit. Shift the sample into the shift register LSB-first and increment the bit index.
  - After bit N-1, where N is derived from `word_len`, go to PARITY if `parity_en`=1, otherwise to STOP.
- PARITY: sample at `cnt`=15 and check it against the data bits per `parity_mode`, then go to STOP.
- STOP: sample at `cnt`=15. Only one stop bit is checked; any second stop bit is treated as idle line.
  - If `rx_full`=0, or `rx_read` is asserted on the same `clk_en` cycle:
    - load `rx_data` (zero-extended to 8 bits);
    - set `rx_full`=1;
    - set `parity_err` from the parity check (0 when `parity_en`=0);
    - set `framing_err` to the inverse of the stop sample.
  - Otherwise: set `overrun`=1 and leave `rx_data`, `parity_err` and `framing_err` unchanged.
  - Next state: IDLE if the stop sample was 1; BREAK if it was 0.
- BREAK: wait for `rxs`=1 on a qualified tick, then go to IDLE. This prevents a held-low line from re-triggering frames.
- `rx_read` on a `clk_en` cycle clears `rx_full`, `parity_err`, `framing_err` and `overrun`. A frame load in the same cycle takes priority over the clear, and `overrun` stays 0.
- `rx_en`=0: the FSM goes to IDLE on the next `clk_en` cycle and any partial frame is discarded. Output flags and `rx_data` are held and remain clearable by `rx_read`.
- `word_len`, `parity_en` and `parity_mode` are sampled live. Changing them mid-frame gives undefined data but must not lock up the FSM.

## Timing
- Reset values: `rx_data`=8'h00; `rx_full`, `parity_err`, `framing_err`, `overrun` and `rx_busy` all 0; FSM in IDLE; `cnt`=0; synchronizer flops 1.
- All registered outputs update only on cycles with `clk_en`=1.
- Input latency: a change on `rxd` reaches `rxs` after `SYNC_STAGES` `clk_en` cycles.
- Frame latency: `rx_full` rises on the qualified tick that samples the stop bit. That tick is 8 + 16·(N+P+1) ticks after the tick that detected the start edge, where P is 1 if `parity_en`=1 and 0 otherwise.
- `rx_busy` rises on the tick that enters START and falls on the cycle the FSM re-enters IDLE.
- Flags are registered and glitch-free. `rx_read` takes effect in the same `clk_en` cycle it is sampled, so the flags read 0 on the following cycle.

## Test plan
- Test 1, basic 8N1 frame: `baud16` every 4 clocks, `word_len`=00, `parity_en`=0, send 0xA5 → `rx_data`=0xA5, `rx_full`=1, all error flags 0, `rx_full` rises 152 ticks after start detect.
- Test 2, 7E1 frame: `word_len`=01, `parity_en`=1, `parity_mode`=01.
  - Send 0x41 with parity bit 0 → `rx_data`=0x41, `parity_err`=0.
  - Resend with parity bit flipped → `parity_err`=1.
- Test 3, framing and break: send 0x55 with stop=0, then hold `rxd` low for 40 ticks → `framing_err`=1 and no second frame while low. After `rxd` returns high, 0x33 is received cleanly.
- Test 4, overrun: receive 0x11 without asserting `rx_read`, then receive 0x22 → `overrun`=1 and `rx_data`=0x11. Pulse `rx_read` → all flags 0.
- Test 5, read/load collision: assert `rx_read` on the exact stop-sample cycle of a second frame 0x7E → `rx_data`=0x7E, `rx_full`=1, `overrun`=0.
- Test 6, glitch and abort:
  - A 4-tick low pulse on `rxd` → FSM returns to IDLE with no flags set.
  - Deassert `rx_en` mid-frame → `rx_busy`=0 and no load.
  - Assert `rst_n` low mid-frame → all outputs return to their reset values immediately.
